bist_signature_unit: RTL

Downstream datapath of the BIST controller. It consumes init/running/finish, generates LFSR test patterns for the circuit under test (CUT), and compacts the CUT responses in a MISR. At finish it compares the signature and the pattern count against golden values and reports pass/fail.

---
 rtl/bist_pkg.sv | 19 +
 rtl/bist_lfsr.sv | 37 +++
 rtl/bist_signature_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST signature datapath.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [7:0]  DEFAULT_POLY   = 8'h1D;
    localparam int unsigned DEFAULT_NCLOCK = 650;

    // One spare bit above what NCLOCK needs, so an overlong run is still distinguishable.
    function automatic int unsigned cnt_width(input int unsigned nclock);
        return $clog2(nclock + 1) + 1;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR with parallel input; acts as a pattern generator (din=0) or a MISR.
module bist_lfsr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = SEED;
        end else if (shift) begin
            q_d = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0) ^ din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bist_signature_unit.sv
// BIST datapath: drives LFSR patterns to the CUT, compacts responses, and grades the run.
module bist_signature_unit
    import bist_pkg::*;
#(
    parameter int unsigned         PI_WIDTH   = 8,
    parameter int unsigned         PO_WIDTH   = 8,
    parameter logic [PI_WIDTH-1:0] TPG_POLY   = PI_WIDTH'(DEFAULT_POLY),
    parameter logic [PI_WIDTH-1:0] TPG_SEED   = PI_WIDTH'(1),
    parameter logic [PO_WIDTH-1:0] MISR_POLY  = PO_WIDTH'(DEFAULT_POLY),
    parameter logic [PO_WIDTH-1:0] GOLDEN_SIG = '0,
    parameter int unsigned         NCLOCK     = DEFAULT_NCLOCK
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              init,
    input  logic                              running,
    input  logic                              finish,
    input  logic [PO_WIDTH-1:0]               cut_out,
    output logic [PI_WIDTH-1:0]               tpg_out,
    output logic [PO_WIDTH-1:0]               signature,
    output logic [cnt_width(NCLOCK)-1:0]      pattern_cnt,
    output logic                              sig_valid,
    output logic                              pass,
    output logic                              count_err
);

    localparam int unsigned CNT_W = cnt_width(NCLOCK);
    // An all-zero seed would lock the TPG at zero.
    localparam logic [PI_WIDTH-1:0] TPG_SEED_EFF = (TPG_SEED == '0) ? PI_WIDTH'(1) : TPG_SEED;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_valid_q, sig_valid_d;
    logic             pass_q, pass_d;
    logic             count_err_q, count_err_d;
    logic             shift_en;

    assign shift_en = !init && (state_q == CAPTURE) && running;

    bist_lfsr #(
        .WIDTH (PI_WIDTH),
        .POLY  (TPG_POLY),
        .SEED  (TPG_SEED_EFF)
    ) u_tpg (
        .clk   (clk),
        .reset (reset),
        .clear (init),
        .shift (shift_en),
        .din   ('0),
        .q     (tpg_out)
    );

    bist_lfsr #(
        .WIDTH (PO_WIDTH),
        .POLY  (MISR_POLY),
        .SEED  ('0)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .clear (init),
        .shift (shift_en),
        .din   (cut_out),
        .q     (signature)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sig_valid_d = sig_valid_q;
        pass_d      = pass_q;
        count_err_d = count_err_q;

        if (init) begin
            state_d     = CAPTURE;
            cnt_d       = '0;
            sig_valid_d = 1'b0;
            pass_d      = 1'b0;
            count_err_d = 1'b0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (running && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (finish) begin
                        state_d = EVAL;
                    end
                end
                // cnt_q and the MISR already include a compaction in the finish cycle.
                EVAL: begin
                    count_err_d = (cnt_q != CNT_W'(NCLOCK));
                    pass_d      = (signature == GOLDEN_SIG) && (cnt_q == CNT_W'(NCLOCK));
                    sig_valid_d = 1'b1;
                    state_d     = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sig_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            count_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sig_valid_q <= sig_valid_d;
            pass_q      <= pass_d;
            count_err_q <= count_err_d;
        end
    end

    assign pattern_cnt = cnt_q;
    assign sig_valid   = sig_valid_q;
    assign pass        = pass_q;
    assign count_err   = count_err_q;

endmodule
